// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memoryModule port between the instruction-fetch path
// (read-only) and the data path (read/write, direct or indirect). One transaction is
// outstanding at a time: IDLE arbitrates and latches the request, BUSY holds the memory
// inputs until dataReady, RELEASE spends one cycle with the memory idle.
//
// Ports:
//   clk, clrN                    clock (rising edge), asynchronous active-low reset
//   fReq/fAddr -> fAck           fetch request, address, one-cycle completion pulse
//   dReq/dAddr/dWe/dIndirect/
//   dWrData -> dAck              data request fields, one-cycle completion pulse
//   rdData                       read data, valid with fAck/dAck
//   err                          high with the ack of a transaction aborted by timeout
//   memCntrl/memAddr/memDataIn/
//   memIndirect                  memory command outputs (memCntrl 00 idle, 01 read, 10 write)
//   memDataOut/memReady          memory read data and completion strobe
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES
// cycles without memReady. Without it, BUSY waits indefinitely and err is tied low.

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clrN,
  input  logic        fReq,
  input  logic [7:0]  fAddr,
  output logic        fAck,
  input  logic        dReq,
  input  logic [7:0]  dAddr,
  input  logic        dWe,
  input  logic        dIndirect,
  input  logic [15:0] dWrData,
  output logic        dAck,
  output logic [15:0] rdData,
  output logic        err,
  output logic [1:0]  memCntrl,
  output logic [7:0]  memAddr,
  output logic [15:0] memDataIn,
  output logic        memIndirect,
  input  logic [15:0] memDataOut,
  input  logic        memReady
);

  localparam logic [1:0] CntrlIdle  = 2'b00;
  localparam logic [1:0] CntrlRead  = 2'b01;
  localparam logic [1:0] CntrlWrite = 2'b10;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_timeout_range_check
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;    // 1: the most recent grant went to the data port
  logic        grant_data_q, grant_data_d;  // port owning the outstanding transaction
  logic [1:0]  mem_cntrl_q, mem_cntrl_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_in_q, mem_data_in_d;
  logic        mem_indirect_q, mem_indirect_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        f_ack_q, f_ack_d;
  logic        d_ack_q, d_ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout_hit;
  // cnt_q counts completed BUSY cycles; this edge is the TIMEOUT_CYCLES-th one.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == TimeoutLim;
`endif

  always_comb begin
    state_d        = state_q;
    last_data_d    = last_data_q;
    grant_data_d   = grant_data_q;
    mem_cntrl_d    = mem_cntrl_q;
    mem_addr_d     = mem_addr_q;
    mem_data_in_d  = mem_data_in_q;
    mem_indirect_d = mem_indirect_q;
    rd_data_d      = rd_data_q;
    f_ack_d        = 1'b0;
    d_ack_d        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (fReq || dReq) begin
          // On a tie the port that did not win last time goes first.
          grant_data_d = dReq && (!fReq || !last_data_q);
          last_data_d  = grant_data_d;
          if (grant_data_d) begin
            mem_cntrl_d    = dWe ? CntrlWrite : CntrlRead;
            mem_addr_d     = dAddr;
            mem_data_in_d  = dWrData;
            mem_indirect_d = dIndirect;
          end else begin
            mem_cntrl_d    = CntrlRead;
            mem_addr_d     = fAddr;
            mem_data_in_d  = '0;
            mem_indirect_d = 1'b0;
          end
          state_d = StBusy;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        if (memReady) begin
          // Writes leave rdData at its previous value.
          if (mem_cntrl_q == CntrlRead) rd_data_d = memDataOut;
          f_ack_d     = !grant_data_q;
          d_ack_d     = grant_data_q;
          mem_cntrl_d = CntrlIdle;
          state_d     = StRelease;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rd_data_d   = '0;
          f_ack_d     = !grant_data_q;
          d_ack_d     = grant_data_q;
          err_d       = 1'b1;
          mem_cntrl_d = CntrlIdle;
          state_d     = StRelease;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      state_q        <= StIdle;
      last_data_q    <= 1'b1;  // fetch wins the first tie
      grant_data_q   <= 1'b0;
      mem_cntrl_q    <= CntrlIdle;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
      mem_indirect_q <= 1'b0;
      rd_data_q      <= '0;
      f_ack_q        <= 1'b0;
      d_ack_q        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      last_data_q    <= last_data_d;
      grant_data_q   <= grant_data_d;
      mem_cntrl_q    <= mem_cntrl_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_in_q  <= mem_data_in_d;
      mem_indirect_q <= mem_indirect_d;
      rd_data_q      <= rd_data_d;
      f_ack_q        <= f_ack_d;
      d_ack_q        <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign fAck        = f_ack_q;
  assign dAck        = d_ack_q;
  assign rdData      = rd_data_q;
  assign memCntrl    = mem_cntrl_q;
  assign memAddr     = mem_addr_q;
  assign memDataIn   = mem_data_in_q;
  assign memIndirect = mem_indirect_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences (contention, reset mid-transaction, timeout, spurious memReady) and a
// randomized run against a transaction-level reference model.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clrN;
  logic        fReq, dReq, dWe, dIndirect, memReady;
  logic [7:0]  fAddr, dAddr;
  logic [15:0] dWrData, memDataOut;
  logic        fAck, dAck, err, memIndirect;
  logic [15:0] rdData, memDataIn;
  logic [1:0]  memCntrl;
  logic [7:0]  memAddr;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .clrN(clrN),
    .fReq(fReq), .fAddr(fAddr), .fAck(fAck),
    .dReq(dReq), .dAddr(dAddr), .dWe(dWe), .dIndirect(dIndirect), .dWrData(dWrData),
    .dAck(dAck), .rdData(rdData), .err(err),
    .memCntrl(memCntrl), .memAddr(memAddr), .memDataIn(memDataIn), .memIndirect(memIndirect),
    .memDataOut(memDataOut), .memReady(memReady)
  );

  logic [45:0] dut_out;
  assign dut_out = {fAck, dAck, err, memCntrl, memAddr, memDataIn, memIndirect, rdData};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    fReq = 0; dReq = 0; fAddr = 0; dAddr = 0; dWe = 0; dIndirect = 0; dWrData = 0;
    memReady = 0; memDataOut = 0;
  endtask

  // Ends at a negedge with clrN released; the next posedge is the first active edge.
  task automatic do_reset();
    drive_idle();
    clrN = 0;
    repeat (2) @(negedge clk);
    clrN = 1;
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic        ind;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mdata;
    logic [1:0]  e_cntrl;
    logic        e_ind;
    logic [15:0] e_din;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[6];

  // One complete transaction starting from IDLE; returns at the negedge after RELEASE.
  task automatic run_vec(input vec_t v, input int idx);
    fReq = !v.is_data; dReq = v.is_data; fAddr = v.addr; dAddr = v.addr;
    dWe = v.we; dIndirect = v.ind; dWrData = v.wdata; memReady = 0;
    @(negedge clk);
    chk($sformatf("vec%0d_grant", idx),
        {memCntrl, memAddr, memDataIn, memIndirect, fAck, dAck},
        {v.e_cntrl, v.addr, v.e_din, v.e_ind, 2'b00});
    // Requester fields change while BUSY; the latched command must not follow them.
    fAddr = ~v.addr; dAddr = ~v.addr; dWrData = ~v.wdata; dWe = ~v.we; dIndirect = ~v.ind;
    for (int i = 1; i <= v.lat; i++) begin
      memReady   = (i == v.lat);
      memDataOut = (i == v.lat) ? v.mdata : 16'h0BAD;
      @(negedge clk);
      if (i < v.lat)
        chk($sformatf("vec%0d_busy%0d", idx, i), {fAck, dAck, memCntrl, memAddr},
            {2'b00, v.e_cntrl, v.addr});
    end
    chk($sformatf("vec%0d_ack", idx), {fAck, dAck, err, memCntrl, rdData, memAddr},
        {!v.is_data, v.is_data, 1'b0, 2'b00, v.e_rd, v.addr});
    fReq = 0; dReq = 0; memReady = 0;
    @(negedge clk);
    chk($sformatf("vec%0d_release", idx), {fAck, dAck, memCntrl}, 4'b0);
  endtask

  // Reference-model state for the randomized run.
  logic        m_out, m_data, m_we, last_data;
  int          free_at, rem;
  logic        e_fack, e_dack;
  logic [1:0]  e_cntrl;
  logic [7:0]  e_addr;
  logic [15:0] e_din, e_rd;
  logic        e_ind;
  logic        in_freq, in_dreq, in_dwe, in_dind, in_ready;
  logic [7:0]  in_faddr, in_daddr;
  logic [15:0] in_dwdata, in_dout;
  logic        f_pend, d_pend;

  initial begin
    logic bad;
    int   fcnt, dcnt;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h3C, 16'hDEAD, 3, 16'hFFC3, 2'b01, 1'b0, 16'h0000, 16'hFFC3};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h81, 16'h1234, 2, 16'hBEEF, 2'b10, 1'b1, 16'h1234, 16'hFFC3};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h10, 16'hAAAA, 1, 16'h5A5A, 2'b01, 1'b0, 16'hAAAA, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'hFF, 16'h0F0F, 4, 16'h0001, 2'b01, 1'b1, 16'h0F0F, 16'h0001};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h7777, 1, 16'h8000, 2'b01, 1'b0, 16'h0000, 16'h8000};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h7E, 16'hFFFF, 1, 16'hC0DE, 2'b10, 1'b0, 16'hFFFF, 16'h8000};

    // Reset values, then spurious memReady while idle.
    do_reset();
    chk("reset_values", dut_out, 46'b0);
    memReady = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (fAck || dAck || memCntrl != 2'b00) bad = 1;
    end
    chk("spurious_ready", bad, 1'b0);
    memReady = 0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Timeout: nothing answers.
    fReq = 1; fAddr = 8'h55;
    @(negedge clk);
    chk("to_grant", {memCntrl, memAddr}, {2'b01, 8'h55});
`ifdef MEM_ARB_TIMEOUT_EN
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (fAck || dAck) bad = 1;
    end
    chk("to_early_ack", bad, 1'b0);
    @(negedge clk);
    chk("to_abort", {fAck, dAck, err, rdData, memCntrl}, {1'b1, 1'b0, 1'b1, 16'h0, 2'b00});
    fReq = 0;
    @(negedge clk);
    chk("to_err_pulse", {err, fAck}, 2'b00);
`else
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (fAck || dAck || err || memCntrl != 2'b01) bad = 1;
    end
    chk("no_timeout_wait", bad, 1'b0);
`endif

    // Contention from reset: F, D, F, D with latency 2, one ack per transaction.
    do_reset();
    fReq = 1; dReq = 1; fAddr = 8'h11; dAddr = 8'h22;
    fcnt = 0; dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        fcnt += int'(fAck); dcnt += int'(dAck);
        if (memCntrl != 2'b00) got = 1;
      end
      chk($sformatf("cont_grant%0d", k), got ? memAddr : 8'h00, (k % 2 == 0) ? 8'h11 : 8'h22);
      @(negedge clk);
      fcnt += int'(fAck); dcnt += int'(dAck);
      memReady = 1; memDataOut = 16'(k + 1);
      @(negedge clk);
      fcnt += int'(fAck); dcnt += int'(dAck);
      chk($sformatf("cont_ack%0d", k), {fAck, dAck, rdData},
          {(k % 2 == 0) ? 2'b10 : 2'b01, 16'(k + 1)});
      memReady = 0;
    end
    @(negedge clk);
    fcnt += int'(fAck); dcnt += int'(dAck);
    chk("cont_ack_counts", {fcnt[7:0], dcnt[7:0]}, {8'd2, 8'd2});

    // Reset two cycles after a grant.
    do_reset();
    fReq = 1; fAddr = 8'h44;
    repeat (3) @(negedge clk);
    chk("rst_mid_pre", memCntrl, 2'b01);
    #2 clrN = 0;
    #1 chk("rst_mid_async", dut_out, 46'b0);
    fReq = 0;
    @(negedge clk);
    clrN = 1; memReady = 1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (fAck || dAck || memCntrl != 2'b00) bad = 1;
    end
    chk("rst_mid_no_ack", bad, 1'b0);
    memReady = 0;
    run_vec(vecs[0], 10);

    // Randomized run against the transaction-level model.
    do_reset();
    m_out = 0; m_data = 0; m_we = 0; last_data = 1; free_at = 0; rem = 0;
    e_cntrl = 0; e_addr = 0; e_din = 0; e_ind = 0; e_rd = 0;
    f_pend = 0; d_pend = 0;
    in_freq = 0; in_dreq = 0; in_dwe = 0; in_dind = 0; in_ready = 0;
    in_faddr = 0; in_daddr = 0; in_dwdata = 0; in_dout = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      e_fack = 0; e_dack = 0;
      if (m_out) begin
        if (in_ready) begin
          if (m_data) e_dack = 1; else e_fack = 1;
          if (!m_we) e_rd = in_dout;
          e_cntrl = 2'b00; m_out = 0; free_at = t + 2;
        end
      end else if (t >= free_at && (in_freq || in_dreq)) begin
        if (in_freq && in_dreq) m_data = !last_data;
        else m_data = in_dreq;
        last_data = m_data;
        m_out = 1;
        rem = $urandom_range(4, 1);
        if (m_data) begin
          m_we = in_dwe; e_cntrl = in_dwe ? 2'b10 : 2'b01;
          e_addr = in_daddr; e_din = in_dwdata; e_ind = in_dind;
        end else begin
          m_we = 0; e_cntrl = 2'b01; e_addr = in_faddr; e_din = 16'h0; e_ind = 0;
        end
      end
      chk($sformatf("rand_t%0d", t), dut_out,
          {e_fack, e_dack, 1'b0, e_cntrl, e_addr, e_din, e_ind, e_rd});
      if (e_fack) f_pend = 0;
      if (e_dack) d_pend = 0;
      if (!f_pend) begin
        fAddr = 8'($urandom);
        if ($urandom_range(1, 0) == 1) f_pend = 1;
      end
      if (!d_pend) begin
        dAddr = 8'($urandom); dWe = 1'($urandom); dIndirect = 1'($urandom);
        dWrData = 16'($urandom);
        if ($urandom_range(1, 0) == 1) d_pend = 1;
      end
      fReq = f_pend; dReq = d_pend;
      if (m_out) begin
        memReady = (rem == 1);
        rem--;
      end else begin
        memReady = ($urandom_range(3, 0) == 0);
      end
      memDataOut = 16'($urandom);
      in_freq = fReq; in_dreq = dReq; in_faddr = fAddr; in_daddr = dAddr; in_dwe = dWe;
      in_dind = dIndirect; in_dwdata = dWrData; in_ready = memReady; in_dout = memDataOut;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of `memoryModule`. It shares the single memory/cache port between the instruction-fetch path (read-only) and the data path (read/write, direct or indirect). It drives the memory's `cntrl`/`addr`/`dataIn`/`isIndirect` inputs, waits for `dataReady`, and returns read data with a one-cycle acknowledge to the granted requester. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: BUSY-state cycle limit before abort; used only when the timeout feature is compiled in; range 1–255.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `clrN`  in  1  reset, asynchronous, active-low.
- `fReq`  in  1  fetch request; held with `fAddr` until `fAck`.
- `fAddr`  in  8  fetch address.
- `fAck`  out  1  one-cycle pulse: fetch complete, `rdData` valid.
- `dReq`  in  1  data request; held with `dAddr`/`dWe`/`dIndirect`/`dWrData` until `dAck`.
- `dAddr`  in  8  data address.
- `dWe`  in  1  1 = write, 0 = read.
- `dIndirect`  in  1  forwarded to memory `isIndirect`.
- `dWrData`  in  16  write data.
- `dAck`  out  1  one-cycle pulse: data transaction complete.
- `rdData`  out  16  read data, valid in the `fAck`/`dAck` cycle.
- `err`  out  1  high with ack when a transaction was aborted by timeout.
- `memCntrl`  out  2  to memory: 00 idle, 01 read, 10 write; 11 never driven.
- `memAddr`  out  8  to memory `addr`.
- `memDataIn`  out  16  to memory `dataIn`.
- `memIndirect`  out  1  to memory `isIndirect`.
- `memDataOut`  in  16  from memory `dataOut`.
- `memReady`  in  1  from memory `dataReady`.

## Operation
- All outputs are registered. Reset values: `memCntrl`=00, `memAddr`=0, `memDataIn`=0, `memIndirect`=0, `fAck`=`dAck`=0, `rdData`=0, `err`=0, state IDLE, `lastGrant`=DATA, so fetch wins the first tie.
- States:
  - IDLE: if any request is present, grant and go to BUSY.
  - BUSY: hold memory inputs until `memReady`=1 (or timeout), then go to RELEASE.
  - RELEASE: one cycle with `memCntrl`=00 and requests ignored, then go to IDLE.
- Arbitration is done in IDLE only:
  - Single requester: that requester is granted.
  - Both requesting: the port opposite `lastGrant` is granted (round-robin).
  - `lastGrant` updates on every grant.
- Grant latch, on the IDLE→BUSY edge:
  - Fetch grant: `memCntrl`=01, `memAddr`=`fAddr`, `memIndirect`=0, `memDataIn`=0.
  - Data grant: `memCntrl`=`dWe`?10:01, `memAddr`=`dAddr`, `memIndirect`=`dIndirect`, `memDataIn`=`dWrData`.
  - Requester inputs are not re-sampled during BUSY.
- Completion, on the edge where `memReady`=1 is sampled in BUSY:
  - `rdData`←`memDataOut` for reads; for writes `rdData` keeps its previous value.
  - Granted ack=1 for one cycle; `err`=0.
  - `memCntrl`←00.
  - Go to RELEASE.
- `memReady` sampled in IDLE or RELEASE is ignored.
- The requester must deassert or change its request in the cycle after its ack. A still-asserted request is treated as a new transaction in the next IDLE.
- Reset asserted mid-transaction: all outputs go to their reset values immediately. The transaction is dropped with no ack, and the requester must re-issue after reset.

## Timing
- Request present in IDLE at edge N: `memCntrl` valid after edge N.
- `memReady` sampled high at edge N+k (k≥1): ack and `rdData` valid after edge N+k, cleared after edge N+k+1.
- Next grant is no earlier than edge N+k+2. Minimum request-to-ack latency is 1 cycle plus memory latency.
- Back-to-back alternating requesters: one transaction per (memory latency + 2) cycles.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` without `memReady`, the block forces `memCntrl`=00, pulses the granted ack with `err`=1, sets `rdData`=0 and goes to RELEASE.
  - `memReady` on the same edge as expiry takes precedence: normal completion, `err`=0.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely, `err` is tied 0.

## Test plan
- Fetch only: `fReq`=1, `fAddr`=8'h3C; memory model returns 16'hFFC3 after 3 cycles → `memCntrl`=01, `memAddr`=3C, `fAck` one cycle with `rdData`=FFC3, `memCntrl`=00 in RELEASE.
- Data write: `dReq`=1, `dWe`=1, `dIndirect`=1, `dAddr`=8'h81, `dWrData`=16'h1234 → `memCntrl`=10, `memIndirect`=1, `memDataIn`=1234, `dAck` after `memReady`, `rdData` unchanged.
- Contention: `fReq` and `dReq` both held continuously from reset → grants alternate F, D, F, D, and each ack occurs exactly once per transaction.
- Reset mid-BUSY: assert `clrN`=0 two cycles after grant → all outputs 0 asynchronously; no ack after release; a new fetch completes normally.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): `memReady` held 0 → ack with `err`=1, `rdData`=0, exactly 4 BUSY cycles after grant; macro off → no ack after 300 cycles.
- Spurious `memReady`=1 in IDLE with no requests → no ack, `memCntrl` stays 00.
